// File: rtl/ahb_cmd_arbiter_if.sv
// Requester-side and AHB-Lite command-port signals of the command arbiter.
// The arbiter connects through 'master'; the surrounding logic uses 'slave'.
interface ahb_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) ();
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*3-1:0]      req_size;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  logic                      o_CMD_Valid;
  logic                      o_CMD_Write;
  logic [ADDR_W-1:0]         o_CMD_Addr;
  logic [DATA_W-1:0]         o_CMD_Data;
  logic [2:0]                o_CMD_Size;
  logic [1:0]                o_CMD_TransferMode;
  logic                      o_CMD_Lock;
  logic                      i_CMD_Ready;
  logic                      i_CMD_Done;
  logic [DATA_W-1:0]         i_CMD_RData;
  logic                      i_CMD_Err;

  logic [IDX_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_write, req_addr, req_data, req_size, req_lock,
    input  i_CMD_Ready, i_CMD_Done, i_CMD_RData, i_CMD_Err,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output o_CMD_Valid, o_CMD_Write, o_CMD_Addr, o_CMD_Data, o_CMD_Size,
    output o_CMD_TransferMode, o_CMD_Lock, grant_id, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, req_size, req_lock,
    output i_CMD_Ready, i_CMD_Done, i_CMD_RData, i_CMD_Err,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  o_CMD_Valid, o_CMD_Write, o_CMD_Addr, o_CMD_Data, o_CMD_Size,
    input  o_CMD_TransferMode, o_CMD_Lock, grant_id, busy
  );
endinterface

// File: rtl/ahb_cmd_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite command port between NUM_REQ requesters,
// with completion tracking, timeout, response routing and locked sequences.
module ahb_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_cmd_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic              keep_q, keep_d;   // req_lock of the command in flight
  logic              lock_q, lock_d;   // locked-sequence flag seen by the master
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic               any_req;
  logic [IDX_W-1:0]   winner;
  int                 scan_idx;
  logic               regrant;
  logic               load;
  logic [IDX_W-1:0]   load_id;
  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] rsp_vec;

  // Scan from the requester after the last one served; the first valid one wins.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_q) + k) % NUM_REQ;
      if (!any_req && bus.req_valid[scan_idx]) begin
        any_req = 1'b1;
        winner  = IDX_W'(scan_idx);
      end
    end
  end

  assign regrant = keep_q && !err_q && bus.req_valid[grant_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    keep_d    = keep_q;
    lock_d    = lock_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    load      = 1'b0;
    load_id   = winner;
    ready_vec = '0;

    case (state_q)
      ST_ARB: begin
        if (any_req) begin
          load    = 1'b1;
          load_id = winner;
          grant_d = winner;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_CMD_Ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.i_CMD_Done) begin
          rdata_d = bus.i_CMD_RData;
          err_d   = bus.i_CMD_Err;
          if (bus.i_CMD_Err) lock_d = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_RESP;
        end
      end
      default: begin  // ST_RESP
        if (regrant) begin
          load    = 1'b1;
          load_id = grant_q;
          state_d = ST_ISSUE;
        end else begin
          last_d  = grant_q;
          lock_d  = 1'b0;
          state_d = ST_ARB;
        end
      end
    endcase

    if (load) begin
      ready_vec[load_id] = 1'b1;
      write_d = bus.req_write[load_id];
      addr_d  = bus.req_addr[int'(load_id)*ADDR_W +: ADDR_W];
      wdata_d = bus.req_data[int'(load_id)*DATA_W +: DATA_W];
      size_d  = bus.req_size[int'(load_id)*3 +: 3];
      keep_d  = bus.req_lock[load_id];
      if (bus.req_lock[load_id]) lock_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_ARB;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      keep_q  <= 1'b0;
      lock_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      keep_q  <= keep_d;
      lock_q  <= lock_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rsp_vec = '0;
    if (state_q == ST_RESP) rsp_vec[grant_q] = 1'b1;
  end

  // The accept pulse is combinational; hold it low in reset so no requester drops a command.
  assign bus.req_ready          = HRESETn ? ready_vec : '0;
  assign bus.rsp_valid          = rsp_vec;
  assign bus.rsp_data           = rdata_q;
  assign bus.rsp_err            = err_q;
  assign bus.o_CMD_Valid        = (state_q == ST_ISSUE);
  assign bus.o_CMD_Write        = write_q;
  assign bus.o_CMD_Addr         = addr_q;
  assign bus.o_CMD_Data         = wdata_q;
  assign bus.o_CMD_Size         = size_q;
  assign bus.o_CMD_TransferMode = 2'b00;
  assign bus.o_CMD_Lock         = lock_q;
  assign bus.grant_id           = grant_q;
  assign bus.busy               = (state_q != ST_ARB);

endmodule
